// File: rtl/opt1_cube_array_if.sv
// rtl/opt1_cube_array_if.sv - operand and result bus of the systolic GEMM cube
interface opt1_cube_array_if #(
   parameter int N         = 8,
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 2*WIDTH + $clog2(N)
);
   logic [WIDTH*N*N-1:0]       A;
   logic [WIDTH*N*N-1:0]       B;
   logic [2*ACC_WIDTH*N*N-1:0] result;

   modport master (output A, output B, input result);
   modport slave  (input A, input B, output result);
endinterface

// File: rtl/opt1_cube_array.sv
// rtl/opt1_cube_array.sv - free-running 3-D systolic INT GEMM cube and pipeline delay helper

module get_pipeline_mulwidth #(
   parameter int N     = 1,
   parameter int WIDTH = 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] signal,
   output logic [WIDTH-1:0] pipeline_signal
);
   logic [WIDTH-1:0] r_stage [N];

   // plain N-stage shift register, cleared as a whole on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= signal;
         for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign pipeline_signal = r_stage[N-1];
endmodule

module opt1_cube_array #(
   parameter int N         = 8,
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 2*WIDTH + $clog2(N)
)(
   input  logic              clk,
   input  logic              rst,
   opt1_cube_array_if.slave  bus
);
   localparam int HALF = N/2;
   localparam int PW   = 2*WIDTH;

   // operand seen by cell (r,c,k), and the registered partial sum leaving it
   logic signed [WIDTH-1:0]     w_a  [N][N][N];
   logic signed [WIDTH-1:0]     w_b  [N][N][N];
   logic signed [ACC_WIDTH-1:0] w_ps [N][N][N];

   genvar gr, gc, gk;
   for (gr = 0; gr < N; gr++) begin : g_row
      for (gc = 0; gc < N; gc++) begin : g_col
         for (gk = 0; gk < N; gk++) begin : g_dep
            logic signed [PW-1:0]        w_prod;
            logic signed [ACC_WIDTH-1:0] w_prod_ext;
            logic signed [ACC_WIDTH-1:0] r_ps;

            // A lane (r,k) enters at c=0 and advances one cell along c per cycle
            if (gc == 0) begin : g_a_in
               assign w_a[gr][gc][gk] = bus.A[WIDTH*(gr*N+gk) +: WIDTH];
            end else begin : g_a_reg
               logic signed [WIDTH-1:0] r_a;
               // A operand hop from cell c-1
               always_ff @(posedge clk) begin
                  if (rst) r_a <= '0;
                  else     r_a <= w_a[gr][gc-1][gk];
               end
               assign w_a[gr][gc][gk] = r_a;
            end

            // B lane (c,k) enters at r=0 and advances one cell along r per cycle
            if (gr == 0) begin : g_b_in
               assign w_b[gr][gc][gk] = bus.B[WIDTH*(gc*N+gk) +: WIDTH];
            end else begin : g_b_reg
               logic signed [WIDTH-1:0] r_b;
               // B operand hop from cell r-1
               always_ff @(posedge clk) begin
                  if (rst) r_b <= '0;
                  else     r_b <= w_b[gr-1][gc][gk];
               end
               assign w_b[gr][gc][gk] = r_b;
            end

            assign w_prod     = w_a[gr][gc][gk] * w_b[gr][gc][gk];
            assign w_prod_ext = {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};

            // k=0 and k=N/2 start the lo and hi chains; others extend the sum from k-1
            if (gk == 0 || gk == HALF) begin : g_head
               // chain head: product alone
               always_ff @(posedge clk) begin
                  if (rst) r_ps <= '0;
                  else     r_ps <= w_prod_ext;
               end
            end else begin : g_tail
               // accumulate onto the partial sum arriving from k-1
               always_ff @(posedge clk) begin
                  if (rst) r_ps <= '0;
                  else     r_ps <= w_ps[gr][gc][gk-1] + w_prod_ext;
               end
            end

            assign w_ps[gr][gc][gk] = r_ps;
         end

         // lo finishes N/2 cycles before hi, so it waits in a delay line
         logic signed [ACC_WIDTH-1:0] r_lo_dly [HALF];
         logic signed [ACC_WIDTH-1:0] r_lo_out;
         logic signed [ACC_WIDTH-1:0] r_hi_out;

         // align lo with hi and register both halves into the result slot
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < HALF; i++) r_lo_dly[i] <= '0;
               r_lo_out <= '0;
               r_hi_out <= '0;
            end else begin
               r_lo_dly[0] <= w_ps[gr][gc][HALF-1];
               for (int i = 1; i < HALF; i++) r_lo_dly[i] <= r_lo_dly[i-1];
               r_lo_out <= r_lo_dly[HALF-1];
               r_hi_out <= w_ps[gr][gc][N-1];
            end
         end

         assign bus.result[(2*(gc*N+gr))*ACC_WIDTH   +: ACC_WIDTH] = r_lo_out;
         assign bus.result[(2*(gc*N+gr)+1)*ACC_WIDTH +: ACC_WIDTH] = r_hi_out;
      end
   end
endmodule

// File: tb/tb_opt1_cube_array.sv
// tb/tb_opt1_cube_array.sv - directed self-checking bench for opt1_cube_array
module tb_opt1_cube_array;
   localparam int LN   = 8;
   localparam int LW   = 8;
   localparam int LACC = 19;
   localparam int KMAX = 17;

   logic       clk;
   logic       rst;
   logic       dl8_in;
   logic       dl8_out;
   logic [7:0] dl1_in;
   logic [7:0] dl1_out;

   int checks;
   int errors;

   int g_a [KMAX][LN][LN];
   int g_b [KMAX][LN][LN];
   int g_c [KMAX][LN][LN];

   opt1_cube_array_if #(.N(LN), .WIDTH(LW), .ACC_WIDTH(LACC)) bus ();

   opt1_cube_array #(.N(LN), .WIDTH(LW), .ACC_WIDTH(LACC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   get_pipeline_mulwidth #(.N(8), .WIDTH(1)) u_dl8 (
      .clk             (clk),
      .rst             (rst),
      .signal          (dl8_in),
      .pipeline_signal (dl8_out)
   );

   get_pipeline_mulwidth #(.N(1), .WIDTH(8)) u_dl1 (
      .clk             (clk),
      .rst             (rst),
      .signal          (dl1_in),
      .pipeline_signal (dl1_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_inputs(input int t, input int nz);
      for (int i = 0; i < LN; i++) begin
         for (int j = 0; j < LN; j++) begin
            int z;
            z = t - i - j;
            if (z >= 0 && z < nz) begin
               bus.A[LW*(i*LN+j) +: LW] = 8'(g_a[z][i][j]);
               bus.B[LW*(i*LN+j) +: LW] = 8'(g_b[z][j][i]);
            end else begin
               bus.A[LW*(i*LN+j) +: LW] = 8'd0;
               bus.B[LW*(i*LN+j) +: LW] = 8'd0;
            end
         end
      end
   endtask

   function automatic int slot_half(input int r, input int c, input int h);
      logic signed [LACC-1:0] v;
      v = bus.result[(2*(c*LN+r)+h)*LACC +: LACC];
      return int'(v);
   endfunction

   task automatic fill_random(input int nz);
      for (int z = 0; z < nz; z++)
         for (int i = 0; i < LN; i++)
            for (int j = 0; j < LN; j++) begin
               g_a[z][i][j] = int'($urandom_range(0, 255)) - 128;
               g_b[z][i][j] = int'($urandom_range(0, 255)) - 128;
            end
   endtask

   task automatic golden(input int nz);
      for (int z = 0; z < nz; z++)
         for (int r = 0; r < LN; r++)
            for (int c = 0; c < LN; c++) begin
               int s;
               s = 0;
               for (int k = 0; k < LN; k++) s += g_a[z][r][k] * g_b[z][k][c];
               g_c[z][r][c] = s;
            end
   endtask

   task automatic flush_zero();
      apply_inputs(0, 0);
      repeat (3*LN) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      bus.A  = {LN*LN{8'h7F}};
      bus.B  = {LN*LN{8'h7F}};
      dl8_in = 1'b1;
      dl1_in = 8'd0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if ($countones(bus.result) !== 0) begin
            errors++;
            $display("FAIL reset_result cycle=%0d ones=%0d expected 0", i, $countones(bus.result));
         end
      end
      rst = 1'b0;
      checks++;
      if (dl8_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_dl8 release got %b expected 0", dl8_out);
      end
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            checks++;
            if ($countones(bus.result) !== 0) begin
               errors++;
               $display("FAIL reset_after ones=%0d expected 0", $countones(bus.result));
            end
         end
         checks++;
         if (dl8_out !== (k == 7)) begin
            errors++;
            $display("FAIL reset_dl8 edge=%0d got %b expected %b", k, dl8_out, (k == 7));
         end
      end
      dl8_in = 1'b0;
      flush_zero();
   endtask

   task automatic test_identity();
      for (int i = 0; i < LN; i++)
         for (int j = 0; j < LN; j++) begin
            g_a[0][i][j] = (i == j) ? 1 : 0;
            g_b[0][i][j] = i + j + 1;
            g_c[0][i][j] = i + j + 1;
         end
      for (int t = 0; t < 1 + 3*LN; t++) begin
         apply_inputs(t, 1);
         @(posedge clk); #1;
         for (int r = 0; r < LN; r++)
            for (int c = 0; c < LN; c++) begin
               int z;
               z = t - r - c - LN;
               if (z == 0) begin
                  checks++;
                  if (slot_half(r, c, 0) + slot_half(r, c, 1) !== g_c[0][r][c]) begin
                     errors++;
                     $display("FAIL identity r=%0d c=%0d got %0d expected %0d", r, c,
                              slot_half(r, c, 0) + slot_half(r, c, 1), g_c[0][r][c]);
                  end
               end
            end
      end
   endtask

   task automatic test_extremes();
      for (int i = 0; i < LN; i++)
         for (int j = 0; j < LN; j++) begin
            g_a[0][i][j] = -128; g_b[0][i][j] = -128; g_c[0][i][j] = 131072;
            g_a[1][i][j] = -128; g_b[1][i][j] = 127;  g_c[1][i][j] = -130048;
         end
      for (int t = 0; t < 2 + 3*LN; t++) begin
         apply_inputs(t, 2);
         @(posedge clk); #1;
         for (int r = 0; r < LN; r++)
            for (int c = 0; c < LN; c++) begin
               int z;
               int lo_exp;
               z = t - r - c - LN;
               lo_exp = (z == 0) ? 65536 : -65024;
               if (z >= 0 && z < 2) begin
                  checks++;
                  if (slot_half(r, c, 0) + slot_half(r, c, 1) !== g_c[z][r][c]) begin
                     errors++;
                     $display("FAIL extreme_sum z=%0d r=%0d c=%0d got %0d expected %0d", z, r, c,
                              slot_half(r, c, 0) + slot_half(r, c, 1), g_c[z][r][c]);
                  end
                  checks++;
                  if (slot_half(r, c, 0) !== lo_exp || slot_half(r, c, 1) !== lo_exp) begin
                     errors++;
                     $display("FAIL extreme_half z=%0d r=%0d c=%0d got lo=%0d hi=%0d expected %0d", z, r, c,
                              slot_half(r, c, 0), slot_half(r, c, 1), lo_exp);
                  end
               end
            end
      end
   endtask

   task automatic run_stream_checked(input int nz, input string tag);
      for (int t = 0; t < nz + 3*LN; t++) begin
         apply_inputs(t, nz);
         @(posedge clk); #1;
         for (int r = 0; r < LN; r++)
            for (int c = 0; c < LN; c++) begin
               int z;
               z = t - r - c - LN;
               if (z >= 0 && z < nz) begin
                  checks++;
                  if (slot_half(r, c, 0) + slot_half(r, c, 1) !== g_c[z][r][c]) begin
                     errors++;
                     $display("FAIL %s z=%0d r=%0d c=%0d got %0d expected %0d", tag, z, r, c,
                              slot_half(r, c, 0) + slot_half(r, c, 1), g_c[z][r][c]);
                  end
               end
            end
      end
   endtask

   task automatic test_back_to_back();
      fill_random(KMAX);
      golden(KMAX);
      for (int rep = 0; rep < 4; rep++) run_stream_checked(KMAX, "stream");
   endtask

   task automatic test_midstream_reset();
      fill_random(KMAX);
      golden(KMAX);
      for (int t = 0; t < 10; t++) begin
         apply_inputs(t, KMAX);
         @(posedge clk); #1;
         for (int r = 0; r < LN; r++)
            for (int c = 0; c < LN; c++) begin
               int z;
               z = t - r - c - LN;
               if (z >= 0) begin
                  checks++;
                  if (slot_half(r, c, 0) + slot_half(r, c, 1) !== g_c[z][r][c]) begin
                     errors++;
                     $display("FAIL pre_reset z=%0d r=%0d c=%0d got %0d expected %0d", z, r, c,
                              slot_half(r, c, 0) + slot_half(r, c, 1), g_c[z][r][c]);
                  end
               end
            end
      end
      apply_inputs(10, KMAX);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ($countones(bus.result) !== 0) begin
         errors++;
         $display("FAIL mid_reset ones=%0d expected 0", $countones(bus.result));
      end
      apply_inputs(0, 0);
      for (int t = 0; t < 3*LN; t++) begin
         @(posedge clk); #1;
         checks++;
         if ($countones(bus.result) !== 0) begin
            errors++;
            $display("FAIL post_reset cycle=%0d ones=%0d expected 0", t, $countones(bus.result));
         end
      end
      fill_random(KMAX);
      golden(KMAX);
      run_stream_checked(KMAX, "clean_run");
   endtask

   task automatic test_delay_line();
      dl1_in = 8'd0;
      @(posedge clk); #1;
      checks++;
      if (dl1_out !== 8'd0) begin
         errors++;
         $display("FAIL dl1 step=0 got %0d expected 0", dl1_out);
      end
      for (int v = 1; v <= 3; v++) begin
         dl1_in = 8'(v);
         @(posedge clk); #1;
         checks++;
         if (dl1_out !== 8'(v)) begin
            errors++;
            $display("FAIL dl1 step=%0d got %0d expected %0d", v, dl1_out, v);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_identity();
      test_extremes();
      test_back_to_back();
      test_midstream_reset();
      test_delay_line();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
